// File: rtl/branch_resolver_pkg.sv
// Shared types, state encodings and helper functions for the branch resolver.
// Contents:
//   addr_t            - 32-bit instruction address type
//   resolver_state_e  - resolver FSM states (2-bit encoding)
//   PC_INC            - sequential fetch increment
//   is_mispredict()   - compares predicted and actual control flow
//   correct_pc()      - fetch PC that IF should resume from
package branch_resolver_pkg;

  typedef logic [31:0] addr_t;

  typedef enum logic [1:0] {
    RESOLVER_IDLE     = 2'd0,
    RESOLVER_FLUSH    = 2'd1,
    RESOLVER_REDIRECT = 2'd2
  } resolver_state_e;

  localparam addr_t PC_INC = 32'd4;

  // A wrong target only matters when the branch was actually taken.
  function automatic logic is_mispredict(input logic  pred_jump,
                                         input addr_t pred_target,
                                         input logic  real_jump,
                                         input addr_t real_target);
    return (pred_jump != real_jump) || (real_jump && (pred_target != real_target));
  endfunction

  // The fall-through PC wraps modulo 2^32 (0xFFFFFFFC + 4 -> 0).
  function automatic addr_t correct_pc(input addr_t pc,
                                       input logic  real_jump,
                                       input addr_t real_target);
    return real_jump ? real_target : (pc + PC_INC);
  endfunction

endpackage

// File: rtl/branch_resolver_sat_counter.sv
// Saturating up-counter used for the resolver statistics.
// Ports:
//   clk   - clock, rising edge
//   rst   - asynchronous active-low reset, clears the count
//   rdy   - global ready; low freezes the count
//   inc   - increment request for this cycle
//   count - current count, sticks at all-ones
module branch_resolver_sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (rdy && inc && (r_count != {WIDTH{1'b1}})) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count = r_count;

endmodule

// File: rtl/branch_resolver.sv
// Commit-side branch resolver. Consumes committed control-flow instructions
// with their fetch-time prediction and actual outcome, trains the predictor,
// and on a misprediction broadcasts a flush followed by a corrected fetch PC.
// Ports:
//   clk, rst, rdy             - clock, async active-low reset, global ready
//   commit_valid/ready        - ROB commit handshake (ready only when idle)
//   commit_is_branch, _pc     - instruction class and PC
//   commit_pred_jump/_target  - prediction made at fetch
//   commit_real_jump/_target  - actual outcome
//   flush_out                 - rollback broadcast, FLUSH_CYCLES cycles long
//   redirect_valid/ready/_pc  - corrected fetch PC handshake toward IF
//   upd_valid/_pc/_taken/_target - one-cycle predictor training pulse
//   branch_cnt, mispredict_cnt   - saturating statistics
module branch_resolver
  import branch_resolver_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1,   // legal range 1..15
  parameter int CNT_WIDTH    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic                 commit_valid,
  output logic                 commit_ready,
  input  logic                 commit_is_branch,
  input  logic [31:0]          commit_pc,
  input  logic                 commit_pred_jump,
  input  logic [31:0]          commit_pred_target,
  input  logic                 commit_real_jump,
  input  logic [31:0]          commit_real_target,
  output logic                 flush_out,
  output logic                 redirect_valid,
  input  logic                 redirect_ready,
  output logic [31:0]          redirect_pc,
  output logic                 upd_valid,
  output logic [31:0]          upd_pc,
  output logic                 upd_taken,
  output logic [31:0]          upd_target,
  output logic [CNT_WIDTH-1:0] branch_cnt,
  output logic [CNT_WIDTH-1:0] mispredict_cnt
);

  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);

  resolver_state_e r_state;
  logic [3:0]      r_flush_cnt;
  logic            r_commit_ready;
  logic            r_flush;
  logic            r_redirect_valid;
  addr_t           r_redirect_pc;
  logic            r_upd_valid;
  addr_t           r_upd_pc;
  logic            r_upd_taken;
  addr_t           r_upd_target;

  logic            w_accept;
  logic            w_branch_acc;
  logic            w_mispredict;

  assign w_accept     = commit_valid && r_commit_ready && rdy;
  assign w_branch_acc = w_accept && commit_is_branch;
  assign w_mispredict = is_mispredict(commit_pred_jump, commit_pred_target,
                                      commit_real_jump, commit_real_target);

  // Resolver FSM with registered outputs. commit_ready tracks the next state,
  // so it is low during reset and rises on the first ready cycle afterwards.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state          <= RESOLVER_IDLE;
      r_flush_cnt      <= '0;
      r_commit_ready   <= 1'b0;
      r_flush          <= 1'b0;
      r_redirect_valid <= 1'b0;
      r_redirect_pc    <= '0;
    end else if (rdy) begin
      case (r_state)
        RESOLVER_IDLE: begin
          if (w_branch_acc && w_mispredict) begin
            r_state        <= RESOLVER_FLUSH;
            r_flush_cnt    <= FLUSH_LOAD;
            r_flush        <= 1'b1;
            r_commit_ready <= 1'b0;
            r_redirect_pc  <= correct_pc(commit_pc, commit_real_jump, commit_real_target);
          end else begin
            r_commit_ready <= 1'b1;
          end
        end
        RESOLVER_FLUSH: begin
          // Leaving on count==1 gives exactly FLUSH_CYCLES cycles of flush_out.
          if (r_flush_cnt == 4'd1) begin
            r_state          <= RESOLVER_REDIRECT;
            r_flush_cnt      <= '0;
            r_flush          <= 1'b0;
            r_redirect_valid <= 1'b1;
          end else begin
            r_flush_cnt <= r_flush_cnt - 4'd1;
          end
        end
        RESOLVER_REDIRECT: begin
          if (redirect_ready) begin
            r_state          <= RESOLVER_IDLE;
            r_redirect_valid <= 1'b0;
            r_commit_ready   <= 1'b1;
          end
        end
        default: begin
          r_state          <= RESOLVER_IDLE;
          r_flush_cnt      <= '0;
          r_flush          <= 1'b0;
          r_redirect_valid <= 1'b0;
          r_commit_ready   <= 1'b1;
        end
      endcase
    end
  end

  // Predictor training pulse: one cycle after each accepted branch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_upd_valid  <= 1'b0;
      r_upd_pc     <= '0;
      r_upd_taken  <= 1'b0;
      r_upd_target <= '0;
    end else if (rdy) begin
      r_upd_valid <= w_branch_acc;
      if (w_branch_acc) begin
        r_upd_pc     <= commit_pc;
        r_upd_taken  <= commit_real_jump;
        r_upd_target <= commit_real_target;
      end
    end
  end

  branch_resolver_sat_counter #(.WIDTH(CNT_WIDTH)) u_branch_cnt (
    .clk   (clk),
    .rst   (rst),
    .rdy   (rdy),
    .inc   (w_branch_acc),
    .count (branch_cnt)
  );

  branch_resolver_sat_counter #(.WIDTH(CNT_WIDTH)) u_mispredict_cnt (
    .clk   (clk),
    .rst   (rst),
    .rdy   (rdy),
    .inc   (w_branch_acc && w_mispredict),
    .count (mispredict_cnt)
  );

  assign commit_ready   = r_commit_ready;
  assign flush_out      = r_flush;
  assign redirect_valid = r_redirect_valid;
  assign redirect_pc    = r_redirect_pc;
  assign upd_valid      = r_upd_valid;
  assign upd_pc         = r_upd_pc;
  assign upd_taken      = r_upd_taken;
  assign upd_target     = r_upd_target;

endmodule

// File: tb/tb_branch_resolver.sv
module tb_branch_resolver;

  localparam int FC = 3;
  localparam int CW = 16;
  localparam int CW_MAX = (1 << CW) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, rdy, redirect_ready;
  logic        commit_valid, commit_is_branch, commit_pred_jump, commit_real_jump;
  logic [31:0] commit_pc, commit_pred_target, commit_real_target;
  logic        commit_ready, flush_out, redirect_valid, upd_valid, upd_taken;
  logic [31:0] redirect_pc, upd_pc, upd_target;
  logic [CW-1:0] branch_cnt, mispredict_cnt;

  // Second instance with 2-bit counters, fed only correctly predicted branches.
  logic        s_valid, s_one, s_zero;
  logic        s_ready, s_flush, s_rv, s_uv, s_utk;
  logic [31:0] s_rpc, s_upc, s_utgt;
  logic [1:0]  s_bc, s_mc;

  branch_resolver #(.FLUSH_CYCLES(FC), .CNT_WIDTH(CW)) u_dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .commit_valid(commit_valid), .commit_ready(commit_ready),
    .commit_is_branch(commit_is_branch), .commit_pc(commit_pc),
    .commit_pred_jump(commit_pred_jump), .commit_pred_target(commit_pred_target),
    .commit_real_jump(commit_real_jump), .commit_real_target(commit_real_target),
    .flush_out(flush_out), .redirect_valid(redirect_valid),
    .redirect_ready(redirect_ready), .redirect_pc(redirect_pc),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target), .branch_cnt(branch_cnt), .mispredict_cnt(mispredict_cnt)
  );

  branch_resolver #(.FLUSH_CYCLES(1), .CNT_WIDTH(2)) u_sat (
    .clk(clk), .rst(rst), .rdy(rdy),
    .commit_valid(s_valid), .commit_ready(s_ready),
    .commit_is_branch(s_one), .commit_pc(commit_pc),
    .commit_pred_jump(s_zero), .commit_pred_target(commit_real_target),
    .commit_real_jump(s_zero), .commit_real_target(commit_real_target),
    .flush_out(s_flush), .redirect_valid(s_rv),
    .redirect_ready(s_one), .redirect_pc(s_rpc),
    .upd_valid(s_uv), .upd_pc(s_upc), .upd_taken(s_utk),
    .upd_target(s_utgt), .branch_cnt(s_bc), .mispredict_cnt(s_mc)
  );

  // Reference model: flags plus a remaining-flush-cycles count.
  bit          m_ready, m_flush, m_rv, m_uv, m_utk;
  logic [31:0] m_rpc, m_upc, m_utgt;
  int          m_fleft, m_bc, m_mc;
  int          n_cmp = 0;
  int          n_fail = 0;

  task automatic model_reset();
    m_ready = 0; m_flush = 0; m_rv = 0; m_uv = 0; m_utk = 0;
    m_rpc = '0; m_upc = '0; m_utgt = '0;
    m_fleft = 0; m_bc = 0; m_mc = 0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    chk("commit_ready", 32'(commit_ready), 32'(m_ready));
    chk("flush_out", 32'(flush_out), 32'(m_flush));
    chk("redirect_valid", 32'(redirect_valid), 32'(m_rv));
    chk("redirect_pc", redirect_pc, m_rpc);
    chk("upd_valid", 32'(upd_valid), 32'(m_uv));
    chk("upd_pc", upd_pc, m_upc);
    chk("upd_taken", 32'(upd_taken), 32'(m_utk));
    chk("upd_target", upd_target, m_utgt);
    chk("branch_cnt", 32'(branch_cnt), 32'(m_bc));
    chk("mispredict_cnt", 32'(mispredict_cnt), 32'(m_mc));
  endtask

  task automatic drive(input bit v, input bit br, input logic [31:0] pc,
                       input bit pj, input logic [31:0] pt,
                       input bit rj, input logic [31:0] rt);
    commit_valid = v; commit_is_branch = br; commit_pc = pc;
    commit_pred_jump = pj; commit_pred_target = pt;
    commit_real_jump = rj; commit_real_target = rt;
  endtask

  // One clock: model predicts from pre-edge inputs, then outputs are compared.
  task automatic tick();
    bit          live, acc, misp;
    logic [31:0] npc;
    longint      seq;
    live = rdy && rst;
    acc  = live && commit_valid && m_ready && commit_is_branch;
    misp = (commit_pred_jump != commit_real_jump) ||
           (commit_real_jump && (commit_pred_target != commit_real_target));
    seq  = (longint'(commit_pc) + 4) % 64'h1_0000_0000;
    npc  = commit_real_jump ? commit_real_target : seq[31:0];
    @(posedge clk);
    if (live) begin
      m_uv = acc;
      if (acc) begin
        m_upc = commit_pc; m_utk = commit_real_jump; m_utgt = commit_real_target;
        if (m_bc < CW_MAX) m_bc++;
        if (misp && m_mc < CW_MAX) m_mc++;
      end
      if (m_flush) begin
        m_fleft--;
        if (m_fleft == 0) begin m_flush = 0; m_rv = 1; end
      end else if (m_rv) begin
        if (redirect_ready) m_rv = 0;
      end else if (acc && misp) begin
        m_flush = 1; m_fleft = FC; m_rpc = npc;
      end
      m_ready = !m_flush && !m_rv;
    end
    #1;
    compare_all();
  endtask

  initial begin
    logic [31:0] rpc, rpt, rrt;
    s_one = 1'b1; s_zero = 1'b0; s_valid = 1'b0;
    rst = 1'b0; rdy = 1'b1; redirect_ready = 1'b0;
    model_reset();

    // Reset held during active commit traffic
    drive(1, 1, 32'h100, 1, 32'h200, 0, 32'h200);
    repeat (3) @(posedge clk);
    #1;
    compare_all();
    chk("rst_commit_ready", 32'(commit_ready), 32'h0);
    chk("rst_flush", 32'(flush_out), 32'h0);
    drive(0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    rst = 1'b1;
    tick();
    chk("rel_commit_ready", 32'(commit_ready), 32'h1);
    chk("rel_branch_cnt", 32'(branch_cnt), 32'h0);

    // Correct taken branch, then back-to-back correct branches
    drive(1, 1, 32'h100, 1, 32'h200, 1, 32'h200);
    tick();
    chk("ct_upd_valid", 32'(upd_valid), 32'h1);
    chk("ct_upd_target", upd_target, 32'h200);
    chk("ct_upd_pc", upd_pc, 32'h100);
    chk("ct_branch_cnt", 32'(branch_cnt), 32'h1);
    chk("ct_flush", 32'(flush_out), 32'h0);
    chk("ct_ready", 32'(commit_ready), 32'h1);
    drive(1, 1, 32'h104, 0, 32'h0, 0, 32'h0);
    tick(); tick(); tick();
    chk("b2b_branch_cnt", 32'(branch_cnt), 32'h4);
    drive(0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    tick();
    chk("ct_upd_drop", 32'(upd_valid), 32'h0);

    // Direction mispredict
    drive(1, 1, 32'h100, 1, 32'h200, 0, 32'h200);
    tick();
    chk("dm_flush", 32'(flush_out), 32'h1);
    chk("dm_ready", 32'(commit_ready), 32'h0);
    chk("dm_mcnt", 32'(mispredict_cnt), 32'h1);
    drive(1, 1, 32'h900, 0, 32'h0, 0, 32'h0);   // must be refused while busy
    for (int i = 0; i < FC - 1; i++) begin
      tick();
      chk("dm_flush_hold", 32'(flush_out), 32'h1);
    end
    tick();
    chk("dm_flush_end", 32'(flush_out), 32'h0);
    chk("dm_rv", 32'(redirect_valid), 32'h1);
    chk("dm_rpc", redirect_pc, 32'h104);
    drive(0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    redirect_ready = 1'b1;
    tick();
    chk("dm_rv_drop", 32'(redirect_valid), 32'h0);
    chk("dm_ready_back", 32'(commit_ready), 32'h1);
    redirect_ready = 1'b0;

    // Target mispredict with redirect_ready withheld
    drive(1, 1, 32'h180, 1, 32'h200, 1, 32'h300);
    tick();
    drive(0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    repeat (FC) tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("tm_rv_hold", 32'(redirect_valid), 32'h1);
      chk("tm_rpc_hold", redirect_pc, 32'h300);
    end
    redirect_ready = 1'b1;
    tick();
    chk("tm_rv_drop", 32'(redirect_valid), 32'h0);
    redirect_ready = 1'b0;

    // Not-taken mispredict at the top of the address space wraps to 0
    drive(1, 1, 32'hFFFF_FFFC, 1, 32'h40, 0, 32'h40);
    tick();
    drive(0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    repeat (FC) tick();
    chk("wrap_rv", 32'(redirect_valid), 32'h1);
    chk("wrap_rpc", redirect_pc, 32'h0);
    redirect_ready = 1'b1;
    tick();
    redirect_ready = 1'b0;

    // Non-branch commit is consumed without training or counting
    drive(1, 0, 32'h500, 1, 32'h1, 0, 32'h2);
    tick();
    chk("nb_upd_valid", 32'(upd_valid), 32'h0);
    chk("nb_branch_cnt", 32'(branch_cnt), 32'h7);
    chk("nb_mcnt", 32'(mispredict_cnt), 32'h3);

    // rdy low for 3 cycles in the middle of a flush
    drive(1, 1, 32'h600, 0, 32'h0, 1, 32'h700);
    tick();
    drive(0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    tick();
    rdy = 1'b0;
    redirect_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("frz_flush", 32'(flush_out), 32'h1);
      chk("frz_rv", 32'(redirect_valid), 32'h0);
    end
    rdy = 1'b1;
    redirect_ready = 1'b0;
    tick();
    chk("frz_flush_resume", 32'(flush_out), 32'h1);
    tick();
    chk("frz_rv", 32'(redirect_valid), 32'h1);
    chk("frz_rpc", redirect_pc, 32'h700);
    redirect_ready = 1'b1;
    tick();
    redirect_ready = 1'b0;

    // Saturation on the 2-bit counter instance
    s_valid = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk("sat_branch_cnt", 32'(s_bc), (i < 3) ? 32'(i) : 32'h3);
    end
    s_valid = 1'b0;
    chk("sat_mcnt", 32'(s_mc), 32'h0);

    // Reset in the middle of a flush aborts without a redirect
    drive(1, 1, 32'h800, 0, 32'h0, 1, 32'h880);
    tick();
    drive(0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    tick();
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    compare_all();
    chk("rstmid_sat_cnt", 32'(s_bc), 32'h0);
    #2;
    rst = 1'b1;
    for (int i = 0; i < FC + 2; i++) begin
      tick();
      chk("rstmid_no_rv", 32'(redirect_valid), 32'h0);
    end

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      rpc = $urandom();
      rpc[1:0] = 2'b00;
      if ($urandom_range(0, 15) == 0) rpc = 32'hFFFF_FFFC;
      rpt = 32'h1000 + 32'($urandom_range(0, 3)) * 32'h10;
      rrt = ($urandom_range(0, 3) == 0) ? 32'h2000 : rpt;
      drive($urandom_range(0, 9) < 7, $urandom_range(0, 4) != 0, rpc,
            1'($urandom_range(0, 1)), rpt, 1'($urandom_range(0, 1)), rrt);
      if ($urandom_range(0, 3) != 0) commit_real_jump = commit_pred_jump;
      rdy = ($urandom_range(0, 9) != 0);
      redirect_ready = 1'($urandom_range(0, 1));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
